// File: rtl/tim_deadtime.sv
// Complementary PWM dead-time inserter with sticky break handling.
// out_p/out_n are mutually exclusive and registered alongside the state.
module tim_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            brk,
    input  logic            brk_clr,
    output logic            out_p,
    output logic            out_n,
    output logic            brk_flag,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DT_P = 3'd1,
        P_ON = 3'd2,
        DT_N = 3'd3,
        N_ON = 3'd4,
        BRK  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_q;
    logic            out_p_q, out_p_d;
    logic            out_n_q, out_n_d;
    logic            brk_flag_q, brk_flag_d;
    logic            busy_q, busy_d;

    // State register; outputs are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
            out_p_q    <= 1'b0;
            out_n_q    <= 1'b0;
            brk_flag_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_in;
            out_p_q    <= out_p_d;
            out_n_q    <= out_n_d;
            brk_flag_q <= brk_flag_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and dead-time counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (brk) begin
            state_d = BRK;
        end else if (state_q == BRK) begin
            if (brk_clr) state_d = IDLE;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = pwm_q ? DT_P : DT_N;
                DT_P: begin
                    // A reference pulse shorter than the dead time is swallowed.
                    if (!pwm_q)              state_d = N_ON;
                    else if (cnt_q == '0)    state_d = P_ON;
                    else                     cnt_d   = cnt_q - DT_W'(1);
                end
                P_ON: if (!pwm_q) state_d = DT_N;
                DT_N: begin
                    if (pwm_q)               state_d = P_ON;
                    else if (cnt_q == '0)    state_d = N_ON;
                    else                     cnt_d   = cnt_q - DT_W'(1);
                end
                N_ON: if (pwm_q) state_d = DT_P;
                default: state_d = IDLE;
            endcase
            // Dead-time codes are captured only on entry to the interval.
            if (state_d == DT_P && state_q != DT_P) cnt_d = dt_rise;
            if (state_d == DT_N && state_q != DT_N) cnt_d = dt_fall;
        end
    end

    // Output decode from the next state.
    always_comb begin
        out_p_d    = 1'b0;
        out_n_d    = 1'b0;
        busy_d     = 1'b0;
        brk_flag_d = 1'b0;
        case (state_d)
            P_ON:       out_p_d    = 1'b1;
            N_ON:       out_n_d    = 1'b1;
            DT_P, DT_N: busy_d     = 1'b1;
            BRK:        brk_flag_d = 1'b1;
            default:    ;
        endcase
    end

    assign out_p    = out_p_q;
    assign out_n    = out_n_q;
    assign brk_flag = brk_flag_q;
    assign busy     = busy_q;

endmodule

// File: doc/tim_deadtime.md
TIM_DEADTIME -- requirements
Module: tim_deadtime

Interface
REQ-001 SHALL have parameter DT_W, default 8: width of dead-time fields and counter.
REQ-002 SHALL have port clk  input  1: clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1: channel enable.
REQ-005 SHALL have port pwm_in  input  1: reference waveform from timer compare output.
REQ-006 SHALL have port dt_rise  input  DT_W: dead-time code inserted before out_p rises.
REQ-007 SHALL have port dt_fall  input  DT_W: dead-time code inserted before out_n rises.
REQ-008 SHALL have port brk  input  1: break request, forces both outputs off.
REQ-009 SHALL have port brk_clr  input  1: clears the sticky break flag.
REQ-010 SHALL have port out_p  output  1: high-side drive, registered.
REQ-011 SHALL have port out_n  output  1: low-side drive, registered.
REQ-012 SHALL have port brk_flag  output  1: sticky break indication, registered.
REQ-013 SHALL have port busy  output  1: high while a dead interval is in progress.

Function
REQ-014 SHALL register pwm_in once into pwm_q; all decisions use pwm_q only.
REQ-015 SHALL implement states IDLE, DT_P, P_ON, DT_N, N_ON, BRK; out_p=1 only in P_ON, out_n=1 only in N_ON, both 0 elsewhere.
REQ-016 SHALL drive out_p and out_n from registers updated at the same edge as the state; out_p=out_n=1 SHALL never occur.
REQ-017 IDLE with en=1: next state DT_P if pwm_q=1, else DT_N.
REQ-018 On entry to DT_P, load counter with dt_rise; on entry to DT_N, load with dt_fall; dt inputs changing mid-interval are ignored.
REQ-019 In DT_x: counter=0 -> x_ON next edge; otherwise decrement; both-off interval is exactly dt+1 clk cycles (dt=0 gives 1 cycle).
REQ-020 In DT_P with pwm_q=0: go directly to N_ON (pulse shorter than dead time swallowed); symmetric for DT_N with pwm_q=1 -> P_ON.
REQ-021 P_ON with pwm_q=0 -> DT_N; N_ON with pwm_q=1 -> DT_P.
REQ-022 Latency: pwm_in change sampled at edge E0 -> outgoing output drops at E1 -> incoming output rises at E1+dt+1.
REQ-023 en=0 in any non-BRK state: IDLE at next edge, counter cleared.
REQ-024 brk=1 at any edge: BRK next edge and brk_flag=1; brk has priority over en, pwm_q and brk_clr.
REQ-025 BRK exits to IDLE only at an edge with brk=0 and brk_clr=1; brk_flag cleared at that edge.
REQ-026 busy=1 exactly when state is DT_P or DT_N.
REQ-027 Counter width DT_W, no wrap: decrement only when nonzero.

Reset
REQ-028 rst=1 SHALL force state IDLE, counter 0, pwm_q 0, out_p=out_n=brk_flag=busy=0, immediately and regardless of clk.
REQ-029 Reset asserted mid dead interval SHALL abandon it; after release, operation restarts from IDLE per REQ-017.

Verification
REQ-030 en=1, pwm_in=0, dt_fall=3: out_n rises 4 cycles after state leaves IDLE; out_p stays 0.
REQ-031 N_ON, dt_rise=5, pwm_in 0->1 sampled at E0: out_n=0 at E1, out_p=1 at E7, busy high E1..E6.
REQ-032 P_ON, dt_fall=8, pwm_in 1-cycle low glitch: DT_N then back to P_ON, out_n never 1.
REQ-033 P_ON, brk pulse with brk_clr=1 same cycle: both outputs 0 next edge, brk_flag=1; brk_clr later with brk=0 -> IDLE, flag 0.
REQ-034 dt_rise=0 and dt_fall=0, pwm_in toggling every 4 cycles: exactly 1 both-off cycle per transition, no overlap.
REQ-035 rst asserted at counter=2 in DT_P: outputs 0 asynchronously; after release returns through IDLE.
